// File: rtl/strip_alloc_if.sv
// Request/response bundle for the strip allocator: one placement request in,
// one write-stage record out per accepted legal request.
interface strip_alloc_if;
  logic       req_valid;
  logic [7:0] req_width;
  logic       req_ready;
  logic       req_error;
  logic       out_valid;
  logic       strike_flag_write;
  logic [3:0] strip_ID_write;
  logic [7:0] old_occupied_width_write;
  logic [7:0] new_occupied_width_write;
  logic [3:0] strike_counter_write;

  modport master (
    output req_valid, req_width,
    input  req_ready, req_error, out_valid, strike_flag_write, strip_ID_write,
           old_occupied_width_write, new_occupied_width_write, strike_counter_write
  );

  modport slave (
    input  req_valid, req_width,
    output req_ready, req_error, out_valid, strike_flag_write, strip_ID_write,
           old_occupied_width_write, new_occupied_width_write, strike_counter_write
  );
endinterface

// File: rtl/strip_alloc.sv
// First-fit strip allocator: places a program width into the lowest strip with
// room, clearing the whole board (a strike) when no strip can take it.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready for a request; illegal widths pulse req_error here
//   SCAN  | testing strip idx for fit, one strip per cycle
//   EMIT  | write-stage record is new; out_valid high for this cycle
module strip_alloc #(
  parameter int         NUM_STRIPS = 14,
  parameter logic [7:0] STRIP_CAP  = 8'd128
) (
  input logic          clk,
  input logic          rst,
  strip_alloc_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] width_q, width_d;
  logic [7:0] occ_q [NUM_STRIPS];
  logic [7:0] occ_d [NUM_STRIPS];
  logic       err_q, err_d;
  logic [3:0] id_q, id_d;
  logic [7:0] old_q, old_d;
  logic [7:0] new_q, new_d;
  logic       flag_q, flag_d;
  logic [3:0] cnt_q, cnt_d;

  logic [8:0] sum;
  logic       fit;
  logic       last_strip;
  logic       width_bad;

  // 9-bit sum so a near-full strip plus a wide request cannot wrap into a false fit
  assign sum        = {1'b0, occ_q[idx_q]} + {1'b0, width_q};
  assign fit        = sum <= {1'b0, STRIP_CAP};
  assign last_strip = idx_q == 4'(NUM_STRIPS - 1);
  assign width_bad  = (bus.req_width == 8'd0) || (bus.req_width > STRIP_CAP);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    width_d = width_q;
    occ_d   = occ_q;
    err_d   = 1'b0;
    id_d    = id_q;
    old_d   = old_q;
    new_d   = new_q;
    flag_d  = flag_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          width_d = bus.req_width;
          idx_d   = 4'd0;
          if (width_bad) begin
            err_d = 1'b1;
          end else begin
            state_d = SCAN;
          end
        end
      end

      SCAN: begin
        if (fit) begin
          id_d         = idx_q;
          old_d        = occ_q[idx_q];
          new_d        = sum[7:0];
          flag_d       = 1'b0;
          occ_d[idx_q] = sum[7:0];
          state_d      = EMIT;
        end else if (last_strip) begin
          // strike: board cleared and the request restarts strip 0
          for (int i = 0; i < NUM_STRIPS; i++) begin
            occ_d[i] = 8'd0;
          end
          occ_d[0] = width_q;
          id_d     = 4'd0;
          old_d    = 8'd0;
          new_d    = width_q;
          flag_d   = 1'b1;
          cnt_d    = cnt_q + 4'd1;
          state_d  = EMIT;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end

      EMIT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      width_q <= 8'd0;
      for (int i = 0; i < NUM_STRIPS; i++) begin
        occ_q[i] <= 8'd0;
      end
      err_q   <= 1'b0;
      id_q    <= 4'd0;
      old_q   <= 8'd0;
      new_q   <= 8'd0;
      flag_q  <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      width_q <= width_d;
      occ_q   <= occ_d;
      err_q   <= err_d;
      id_q    <= id_d;
      old_q   <= old_d;
      new_q   <= new_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_ready                = (state_q == IDLE);
  assign bus.req_error                = err_q;
  assign bus.out_valid                = (state_q == EMIT);
  assign bus.strike_flag_write        = flag_q;
  assign bus.strip_ID_write           = id_q;
  assign bus.old_occupied_width_write = old_q;
  assign bus.new_occupied_width_write = new_q;
  assign bus.strike_counter_write     = cnt_q;

endmodule

// File: doc/strip_alloc.md
STRIP_ALLOC -- requirements
Module: strip_alloc

Interface
REQ-001 SHALL have parameter NUM_STRIPS, default 14, meaning the number of placement strips.
REQ-002 SHALL have parameter STRIP_CAP, default 8'd128, meaning the usable width of each strip.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 req_valid  input  1  placement request present.
REQ-006 req_width  input  8  requested program width.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_error  output  1  one-cycle pulse: request rejected.
REQ-009 out_valid  output  1  one-cycle pulse: write-stage outputs are new.
REQ-010 strike_flag_write  output  1  placement caused a strike (board cleared).
REQ-011 strip_ID_write  output  4  chosen strip.
REQ-012 old_occupied_width_write  output  8  strip occupancy before placement.
REQ-013 new_occupied_width_write  output  8  strip occupancy after placement.
REQ-014 strike_counter_write  output  4  cumulative strike count.

Function
REQ-015 SHALL hold occupancy array occ[0..NUM_STRIPS-1], 8 bits each, all 0 after reset.
REQ-016 SHALL implement FSM with states IDLE, SCAN, EMIT; req_ready=1 only in IDLE.
REQ-017 IDLE: request accepted on edge where req_valid&req_ready; the block SHALL latch req_width and set scan index idx=0.
REQ-018 Accepted width of 0 or greater than STRIP_CAP SHALL be rejected: req_error pulses in the cycle after acceptance, FSM stays IDLE, no other state or output changes.
REQ-019 Legal width SHALL move the FSM to SCAN.
REQ-020 SCAN SHALL evaluate one strip per cycle, strip idx, first-fit ascending; fit means occ[idx]+width <= STRIP_CAP, computed 9-bit with no overflow.
REQ-021 On fit, the block SHALL at the same edge: register strip_ID=idx, old=occ[idx], new=occ[idx]+width, strike_flag=0; write occ[idx]=new; go to EMIT.
REQ-022 No fit and idx<NUM_STRIPS-1 SHALL increment idx and stay in SCAN.
REQ-023 No fit at idx=NUM_STRIPS-1 (strike) SHALL, at the same edge: clear all occ; set occ[0]=width; register strip_ID=0, old=0, new=width, strike_flag=1; increment strike counter (4-bit, wraps 15->0); go to EMIT.
REQ-024 strike_counter_write SHALL reflect the counter including the current strike at the same edge.
REQ-025 EMIT SHALL assert out_valid for exactly one cycle, then return to IDLE.
REQ-026 Latency: with acceptance at edge E0 and the fit at strip k, outputs update at E0+k+1 and out_valid is high during the cycle after that edge; for a strike, outputs update at E0+NUM_STRIPS.
REQ-027 Write-stage outputs SHALL hold their last values between emits.
REQ-028 req_valid while not in IDLE SHALL be ignored, with no queuing.
REQ-029 An exact fill (occ+width == STRIP_CAP) SHALL count as a fit.

Reset
REQ-030 rst low SHALL asynchronously force: FSM=IDLE, idx=0, all occ=0, strike counter=0, all outputs 0 except req_ready=1, including mid-SCAN.
REQ-031 After rst deasserts, the first accepted request SHALL behave as in a fresh start; an in-flight request aborted by reset SHALL produce no out_valid.

Verification
REQ-032 Reset, then request width 10 -> out_valid 2 cycles after accept edge; ID=0, old=0, new=10, flag=0, counter=0.
REQ-033 Widths 100 then 28 then 1 -> ID 0 (0->100), ID 0 (100->128, exact fit), ID 1 (0->1, latency 3 cycles).
REQ-034 Fill all 14 strips to 128, then request width 5 -> at E0+14: flag=1, ID=0, old=0, new=5, counter=1; next width 5 -> ID 0, old 5, new 10.
REQ-035 Request widths 0 and 200 -> req_error pulse each; no out_valid; occupancy unchanged.
REQ-036 Assert rst mid-SCAN at idx=6 -> outputs 0, req_ready=1 immediately; no out_valid; next request lands at strip 0 with old=0.
REQ-037 Force 16 strikes -> counter reads 1..15 then 0 on the 16th.
